alu_sequencer: RTL and testbench

Multicycle issue/collect sequencer that drives the processor's `logic_unit` from the control-unit side. It accepts one ALU/shift/branch request through a valid/ready handshake and drives `ALUOp`, `SHAMT` and the step `COUNTER` for the required number of cycles. It samples `ALUOut`, `OVERFLOW`, `ZERO` and `Update_UC` on the last step, then holds the packaged result until the control unit consumes it.

---
 rtl/alu_sequencer.sv | 99 +++++++++
 tb/tb_alu_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Issue/collect sequencer for logic_unit: accepts one request, steps COUNTER
// through the programmed number of cycles, captures the final result and holds it.
module alu_sequencer #(
   parameter int unsigned MAX_STEPS = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [4:0]  req_shamt,
   input  logic [1:0]  req_steps,
   input  logic        req_chk_ov,
   input  logic        req_branch,
   output logic [3:0]  ALUOp,
   output logic [4:0]  SHAMT,
   output logic [1:0]  COUNTER,
   input  logic [31:0] ALUOut,
   input  logic        OVERFLOW,
   input  logic        ZERO,
   input  logic        Update_UC,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_zero,
   output logic        rsp_taken,
   output logic        rsp_exc
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [1:0] STEP_LIMIT = (MAX_STEPS > 3) ? 2'd3 : 2'(MAX_STEPS);

   state_t     state;
   logic [1:0] steps;
   logic       chk_ov;
   logic       branch;
   logic [1:0] steps_clamped;

   assign steps_clamped = (req_steps > STEP_LIMIT) ? STEP_LIMIT : req_steps;

   // ALUOp/SHAMT/COUNTER double as the latched op, shamt and step count.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         rsp_taken  <= 1'b0;
         rsp_exc    <= 1'b0;
         ALUOp      <= '0;
         SHAMT      <= '0;
         COUNTER    <= '0;
         steps      <= '0;
         chk_ov     <= 1'b0;
         branch     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  state     <= EXEC;
                  req_ready <= 1'b0;
                  ALUOp     <= req_op;
                  SHAMT     <= req_shamt;
                  COUNTER   <= '0;
                  steps     <= steps_clamped;
                  chk_ov    <= req_chk_ov;
                  branch    <= req_branch;
               end
            end
            EXEC: begin
               if (COUNTER < steps) begin
                  COUNTER <= COUNTER + 2'd1;
               end else begin
                  rsp_result <= ALUOut;
                  rsp_zero   <= ZERO;
                  rsp_exc    <= OVERFLOW & chk_ov;
                  rsp_taken  <= Update_UC & branch;
                  rsp_valid  <= 1'b1;
                  ALUOp      <= '0;
                  SHAMT      <= '0;
                  COUNTER    <= '0;
                  state      <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed requests push expected responses,
// a negedge monitor pops and compares on every consumed response.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0, req_valid2 = 1'b0;
   logic        req_ready, req_ready2;
   logic [3:0]  req_op = '0;
   logic [4:0]  req_shamt = '0;
   logic [1:0]  req_steps = '0;
   logic        req_chk_ov = 1'b0, req_branch = 1'b0;
   logic [3:0]  ALUOp, ALUOp2;
   logic [4:0]  SHAMT, SHAMT2;
   logic [1:0]  COUNTER, COUNTER2;
   logic [31:0] ALUOut = '0;
   logic        OVERFLOW = 1'b0, ZERO = 1'b0, Update_UC = 1'b0;
   logic        rsp_valid, rsp_valid2;
   logic        rsp_ready = 1'b1, rsp_ready2 = 1'b1;
   logic [31:0] rsp_result, rsp_result2;
   logic        rsp_zero, rsp_zero2, rsp_taken, rsp_taken2, rsp_exc, rsp_exc2;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] result;
      logic        zero;
      logic        taken;
      logic        exc;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   alu_sequencer u_dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_shamt(req_shamt), .req_steps(req_steps),
      .req_chk_ov(req_chk_ov), .req_branch(req_branch),
      .ALUOp(ALUOp), .SHAMT(SHAMT), .COUNTER(COUNTER),
      .ALUOut(ALUOut), .OVERFLOW(OVERFLOW), .ZERO(ZERO), .Update_UC(Update_UC),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_zero(rsp_zero), .rsp_taken(rsp_taken), .rsp_exc(rsp_exc)
   );

   alu_sequencer #(.MAX_STEPS(2)) u_dut2 (
      .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(req_ready2),
      .req_op(req_op), .req_shamt(req_shamt), .req_steps(req_steps),
      .req_chk_ov(req_chk_ov), .req_branch(req_branch),
      .ALUOp(ALUOp2), .SHAMT(SHAMT2), .COUNTER(COUNTER2),
      .ALUOut(ALUOut), .OVERFLOW(OVERFLOW), .ZERO(ZERO), .Update_UC(Update_UC),
      .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_result(rsp_result2),
      .rsp_zero(rsp_zero2), .rsp_taken(rsp_taken2), .rsp_exc(rsp_exc2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every consumed response must match the oldest expected entry.
   always @(negedge clk) begin
      if (!reset && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp: got result %h expected no response", rsp_result);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_result", rsp_result, e.result);
            chk("rsp_zero", rsp_zero, e.zero);
            chk("rsp_taken", rsp_taken, e.taken);
            chk("rsp_exc", rsp_exc, e.exc);
         end
      end
   end

   // Drives one request; non-final steps carry junk logic_unit values that must be ignored.
   task automatic run_req(input logic [3:0] op, input logic [4:0] shamt, input logic [1:0] steps,
                          input logic chk_ov, input logic br, input int unsigned n,
                          input logic [31:0] fout, input logic fov, input logic fz, input logic fuc,
                          input logic exp_taken, input logic exp_exc, input int unsigned hold);
      exp_t e;
      @(posedge clk); #1;
      req_op = op; req_shamt = shamt; req_steps = steps;
      req_chk_ov = chk_ov; req_branch = br; req_valid = 1'b1;
      @(negedge clk);
      chk("req_ready_idle", req_ready, 1'b1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int unsigned k = 0; k <= n; k++) begin
         if (k == n) begin
            ALUOut = fout; OVERFLOW = fov; ZERO = fz; Update_UC = fuc;
            rsp_ready = (hold == 0);
            e.result = fout; e.zero = fz; e.taken = exp_taken; e.exc = exp_exc;
            exp_q.push_back(e);
         end else begin
            ALUOut = 32'hDEAD_0000 + k; OVERFLOW = 1'b1; ZERO = ~fz; Update_UC = 1'b1;
         end
         @(negedge clk);
         chk("exec_counter", COUNTER, k);
         chk("exec_aluop", ALUOp, op);
         chk("exec_shamt", SHAMT, shamt);
         chk("exec_no_rsp", rsp_valid, 1'b0);
         @(posedge clk); #1;
         ALUOut = 32'hFFFF_0000; OVERFLOW = 1'b1; ZERO = 1'b1; Update_UC = 1'b1;
      end
      @(negedge clk);
      chk("resp_valid", rsp_valid, 1'b1);
      chk("resp_aluop_zero", ALUOp, 4'd0);
      chk("resp_counter_zero", COUNTER, 2'd0);
      chk("resp_not_ready", req_ready, 1'b0);
      for (int unsigned i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         req_valid = 1'b1; req_op = 4'hF;
         @(negedge clk);
         chk("hold_valid", rsp_valid, 1'b1);
         chk("hold_result", rsp_result, fout);
         chk("hold_zero", rsp_zero, fz);
         chk("hold_taken", rsp_taken, exp_taken);
         chk("hold_req_ready", req_ready, 1'b0);
      end
      if (hold != 0) begin
         @(posedge clk); #1;
         req_valid = 1'b0; rsp_ready = 1'b1;
         @(negedge clk);
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("back_idle_ready", req_ready, 1'b1);
      chk("back_idle_rsp_valid", rsp_valid, 1'b0);
      chk("back_idle_aluop", ALUOp, 4'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_result", rsp_result, 32'd0);
      chk("rst_flags", {rsp_zero, rsp_taken, rsp_exc}, 3'b000);
      chk("rst_aluop", ALUOp, 4'd0);
      chk("rst_shamt", SHAMT, 5'd0);
      chk("rst_counter", COUNTER, 2'd0);

      //       op     shamt steps chk br  n  result          ov    z     uc    taken exc  hold
      run_req(4'd1, 5'd0, 2'd0, 1'b1, 1'b0, 0, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      run_req(4'd8, 5'd5, 2'd2, 1'b0, 1'b0, 2, 32'h0000_00A0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      run_req(4'd3, 5'd1, 2'd3, 1'b0, 1'b0, 3, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      run_req(4'd2, 5'd0, 2'd1, 1'b0, 1'b0, 1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      run_req(4'd2, 5'd0, 2'd1, 1'b1, 1'b0, 1, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      run_req(4'd6, 5'd0, 2'd0, 1'b0, 1'b1, 0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4);
      run_req(4'd6, 5'd0, 2'd0, 1'b0, 1'b0, 0, 32'h0000_0003, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);

      // Reset during COUNTER=1 of a 3-step op discards the request.
      @(posedge clk); #1;
      req_op = 4'd9; req_shamt = 5'd2; req_steps = 2'd2; req_chk_ov = 1'b1; req_branch = 1'b1;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("pre_reset_counter", COUNTER, 2'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("midreset_ready", req_ready, 1'b1);
      chk("midreset_aluop", ALUOp, 4'd0);
      chk("midreset_counter", COUNTER, 2'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("midreset_no_rsp", rsp_valid, 1'b0);
      end

      // MAX_STEPS=2 instance: req_steps=3 clamps to a 0,1,2 sequence.
      @(posedge clk); #1;
      req_op = 4'd4; req_shamt = 5'd3; req_steps = 2'd3; req_chk_ov = 1'b0; req_branch = 1'b0;
      req_valid2 = 1'b1;
      @(negedge clk);
      chk("clamp_ready", req_ready2, 1'b1);
      @(posedge clk); #1;
      req_valid2 = 1'b0;
      for (int unsigned k = 0; k <= 2; k++) begin
         ALUOut = (k == 2) ? 32'h0000_0C0D : 32'h0000_0BAD;
         @(negedge clk);
         chk("clamp_counter", COUNTER2, k);
         chk("clamp_aluop", ALUOp2, 4'd4);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("clamp_rsp_valid", rsp_valid2, 1'b1);
      chk("clamp_rsp_result", rsp_result2, 32'h0000_0C0D);
      chk("clamp_counter_done", COUNTER2, 2'd0);

      repeat (2) @(negedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
